alu_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the 8-bit registered ALU (opcode[2:0], a, b in; out1 registered one clock later). It accepts tagged commands over a valid/ready interface, buffers them, and issues one per cycle to the ALU. It captures the ALU result at the correct cycle and returns it with its tag through a buffered valid/ready result port. Credit-based issue means no ALU result is ever dropped, even though the ALU itself has no stall input.

---
 rtl/alu_cmd_seq_pkg.sv | 21 ++
 rtl/alu_cmd_seq_if.sv | 32 +++
 rtl/alu_cmd_seq_sync_fifo.sv | 64 ++++++
 rtl/alu_cmd_seq.sv | 123 ++++++++++++
 tb/tb_alu_cmd_seq.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings,
// default widths and a small sizing helper.
package alu_cmd_seq_pkg;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_TAG_W = 4;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_ANDN = 3'b011,
        OP_ORN  = 3'b100
    } alu_op_e;

    // One spare bit so that res_count + iss_v + alu_v cannot wrap.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1) + 1;
    endfunction

endpackage

// File: rtl/alu_cmd_seq_if.sv
// Command and result handshake bundle of the ALU command sequencer.
// The master side produces commands and consumes results.
interface alu_cmd_seq_if
    import alu_cmd_seq_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int TAG_W = DEFAULT_TAG_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_opcode;
    logic [W-1:0]     cmd_a;
    logic [W-1:0]     cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [TAG_W-1:0] res_tag;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, res_ready,
        input  cmd_ready, res_valid, res_data, res_tag
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, res_ready,
        output cmd_ready, res_valid, res_data, res_tag
    );

endinterface

// File: rtl/alu_cmd_seq_sync_fifo.sv
// Show-ahead synchronous FIFO: pop_data is the current head entry.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Buffers tagged commands, issues them to a registered ALU under result-FIFO
// credits, and returns each ALU result with its tag in issue order.
module alu_cmd_seq
    import alu_cmd_seq_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter int TAG_W     = DEFAULT_TAG_W,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_cmd_seq_if.slave  bus,
    output logic [2:0]    alu_opcode,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_out,
    output logic          busy
);

    localparam int CMD_W = 3 + 2 * W + TAG_W;
    localparam int RES_W = W + TAG_W;
    localparam int RC_W  = $clog2(RES_DEPTH + 1);
    localparam int UW    = credit_width(RES_DEPTH);

    logic [CMD_W-1:0]           cmd_head;
    logic                       cmd_full;
    logic                       cmd_empty;
    logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count;
    logic                       cmd_push;

    logic [RES_W-1:0]           res_head;
    logic                       res_full;
    logic                       res_empty;
    logic [RC_W-1:0]            res_count;
    logic                       res_push;
    logic                       res_pop;

    logic [2:0]                 head_opcode;
    logic [W-1:0]               head_a;
    logic [W-1:0]               head_b;
    logic [TAG_W-1:0]           head_tag;

    logic [UW-1:0]              credits_used;
    logic                       issue;

    logic [2:0]                 alu_opcode_reg;
    logic [W-1:0]               alu_a_reg;
    logic [W-1:0]               alu_b_reg;
    logic                       iss_v_reg;
    logic [TAG_W-1:0]           iss_tag_reg;
    logic                       alu_v_reg;
    logic [TAG_W-1:0]           alu_tag_reg;

    assign bus.cmd_ready = ~cmd_full;
    assign cmd_push      = bus.cmd_valid & ~cmd_full;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data ({bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_tag}),
        .pop       (issue),
        .pop_data  (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .count     (cmd_count)
    );

    assign {head_opcode, head_a, head_b, head_tag} = cmd_head;

    // Every issued command owns a result slot until it is popped, so the
    // ALU output always has room two cycles after issue.
    assign credits_used = UW'(res_count) + UW'(iss_v_reg) + UW'(alu_v_reg);
    assign issue        = ~cmd_empty & (credits_used < UW'(RES_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode_reg <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            iss_v_reg      <= 1'b0;
            iss_tag_reg    <= '0;
            alu_v_reg      <= 1'b0;
            alu_tag_reg    <= '0;
        end else begin
            iss_v_reg <= issue;
            if (issue) begin
                alu_opcode_reg <= head_opcode;
                alu_a_reg      <= head_a;
                alu_b_reg      <= head_b;
                iss_tag_reg    <= head_tag;
            end
            alu_v_reg   <= iss_v_reg;
            alu_tag_reg <= iss_tag_reg;
        end
    end

    assign alu_opcode = alu_opcode_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;

    assign res_push = alu_v_reg & ~res_full;
    assign res_pop  = bus.res_valid & bus.res_ready;

    sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (res_push),
        .push_data ({alu_out, alu_tag_reg}),
        .pop       (res_pop),
        .pop_data  (res_head),
        .full      (res_full),
        .empty     (res_empty),
        .count     (res_count)
    );

    assign bus.res_valid              = ~res_empty;
    assign {bus.res_data, bus.res_tag} = res_head;

    assign busy = (cmd_count != '0) | iss_v_reg | alu_v_reg | ~res_empty;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a registered ALU model in the loop
// and an in-order result scoreboard.
module tb_alu_cmd_seq;
    import alu_cmd_seq_pkg::*;

    localparam int W     = 8;
    localparam int TAG_W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   alu_opcode;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out = '0;
    logic         busy;

    int n_checks = 0;
    int n_fails  = 0;
    logic [W+TAG_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    alu_cmd_seq_if #(.W(W), .TAG_W(TAG_W)) bus ();

    alu_cmd_seq #(.W(W), .TAG_W(TAG_W), .CMD_DEPTH(4), .RES_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .busy       (busy)
    );

    // External registered ALU.
    always @(posedge clk) begin
        case (alu_opcode)
            OP_AND:  alu_out <= alu_a & alu_b;
            OP_OR:   alu_out <= alu_a | alu_b;
            OP_XOR:  alu_out <= alu_a ^ alu_b;
            OP_ANDN: alu_out <= alu_a & ~alu_b;
            default: alu_out <= alu_a | ~alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [3:0] tag);
        logic rdy;
        int   n;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_tag    = tag;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 50) begin
            rdy = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd_accept", 32'(rdy), 32'd1);
        $display("CMD op=%b a=%h b=%h tag=%h", op, a, b, tag);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(busy || exp_q.size() != 0), 32'd0);
    endtask

    // Scoreboard: a result is consumed at the edge after this sample.
    always @(negedge clk) begin
        logic [W+TAG_W-1:0] e;
        if (rst_n && bus.res_valid && bus.res_ready) begin
            $display("RES data=%h tag=%h", bus.res_data, bus.res_tag);
            if (exp_q.size() == 0) begin
                check("res_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("res_data", 32'(bus.res_data), 32'(e[W+TAG_W-1:TAG_W]));
                check("res_tag",  32'(bus.res_tag),  32'(e[TAG_W-1:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) check("res_no_overflow", 32'(dut.alu_v_reg & dut.res_full), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        int n;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.cmd_tag    = '0;
        bus.res_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data",  32'(bus.res_data),  32'd0);
        check("rst_res_tag",   32'(bus.res_tag),   32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_alu",       32'({alu_opcode, alu_a, alu_b}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single command, latency and hold
        send_cmd(3'b000, 8'hF0, 8'h3C, 4'h1);
        check("single_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("single_lat_k1", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        check("single_lat_k2", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        check("single_lat_k3", 32'(bus.res_valid), 32'd1);
        check("single_data",   32'(bus.res_data),  32'h30);
        check("single_tag",    32'(bus.res_tag),   32'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_data",  32'(bus.res_data),  32'h30);
            check("hold_tag",   32'(bus.res_tag),   32'h1);
        end
        check("idle_alu", 32'({alu_opcode, alu_a, alu_b}), 32'({3'b000, 8'hF0, 8'h3C}));
        exp_q.push_back({8'h30, 4'h1});
        bus.res_ready = 1'b1;
        wait_idle("single_drain", 20);

        // Mixed opcodes back to back
        exp_q.push_back({8'hF0, 4'h2});
        exp_q.push_back({8'h55, 4'h3});
        exp_q.push_back({8'h0F, 4'h4});
        send_cmd(3'b011, 8'hFF, 8'h0F, 4'h2);
        send_cmd(3'b010, 8'hAA, 8'hFF, 4'h3);
        send_cmd(3'b111, 8'h00, 8'hF0, 4'h4);
        wait_idle("mixed_drain", 20);

        // Backpressure: credits cap issue at four
        bus.res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_cmd(3'b001, 8'(i), 8'h10, 4'(i));
            exp_q.push_back({8'(i) | 8'h10, 4'(i)});
        end
        check("bp_cmd_full", 32'(bus.cmd_ready), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("bp_still_full", 32'(bus.cmd_ready), 32'd0);
        check("bp_res_valid",  32'(bus.res_valid), 32'd1);
        check("bp_last_issue", 32'(alu_a),         32'd3);
        bus.res_ready = 1'b1;
        wait_idle("bp_drain", 40);

        // Throughput: one result per cycle
        for (int i = 0; i < 16; i++) exp_q.push_back({8'(i) ^ 8'h5A, 4'(i)});
        fork
            begin
                for (int i = 0; i < 16; i++) send_cmd(3'b010, 8'(i), 8'h5A, 4'(i));
            end
            begin
                n = 0;
                while (!bus.res_valid && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                vcount = 0;
                for (int i = 0; i < 16; i++) begin
                    if (bus.res_valid) vcount++;
                    @(posedge clk); #1;
                end
                check("thru_no_bubble", 32'(vcount), 32'd16);
            end
        join
        wait_idle("thru_drain", 20);

        // Reset mid-flight
        bus.res_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_cmd(3'b000, 8'hFF, 8'(i), 4'(i));
        check("mid_busy", 32'(busy), 32'd1);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_res",       32'({bus.res_data, bus.res_tag}), 32'd0);
        check("mid_rst_busy",      32'(busy), 32'd0);
        check("mid_rst_alu",       32'({alu_opcode, alu_a, alu_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid || busy) vcount++;
        end
        check("mid_no_stale", 32'(vcount), 32'd0);
        check("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        exp_q.push_back({8'h0F, 4'h9});
        send_cmd(3'b000, 8'hFF, 8'h0F, 4'h9);
        wait_idle("mid_recover", 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
